// File: rtl/debug_uart_cmd_rx.sv
// Host debug link receive path: 8N1 deserialiser, one-byte holding register and command parser
// that drives the debugger bus master and queues response bytes for the UART transmitter.
`timescale 1ns/1ps
module debug_uart_cmd_rx #(
    parameter int CLKS_PER_BIT = 431,
    parameter int SYNC_STAGES  = 2
) (
    input  logic        clk,
    input  logic        asyncrst_n,
    input  logic        rx,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        core_rst,
    output logic        frame_err,
    output logic        overrun
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [6:0] OP_SET_COUNT = 7'd2;
    localparam logic [6:0] OP_SET_ADDR  = 7'd3;
    localparam logic [6:0] OP_READ      = 7'd4;
    localparam logic [6:0] OP_WRITE     = 7'd5;
    localparam logic [6:0] OP_ALIVE     = 7'd6;
    localparam logic [6:0] OP_CORE_RST  = 7'd7;
    localparam logic [6:0] OP_CORE_NORM = 7'd8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    typedef enum logic [1:0] {
        P_CMD,
        P_ARG,
        P_EXEC,
        P_RESP
    } p_state_t;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic                   rx_s;
    logic                   rx_prev_reg;

    rx_state_t              rx_state_reg;
    logic [CW-1:0]          bit_cnt_reg;
    logic [2:0]             bit_idx_reg;
    logic [7:0]             shift_reg;
    logic [7:0]             byte_reg;
    logic                   byte_strobe_reg;

    logic                   hold_valid_reg;
    logic [7:0]             hold_data_reg;
    logic                   hold_take;

    p_state_t               p_state_reg;
    logic [6:0]             op_reg;
    logic [2:0]             arg_left_reg;
    logic [23:0]            arg_shift_reg;
    logic [7:0]             count_reg;
    logic [7:0]             reads_left_reg;
    logic [23:0]            resp_buf_reg;
    logic [1:0]             resp_left_reg;

    // Synchroniser idles high so leaving reset never looks like a start bit.
    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            sync_reg <= '1;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
        end
    end

    assign rx_s = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            rx_state_reg    <= RX_IDLE;
            rx_prev_reg     <= 1'b1;
            bit_cnt_reg     <= '0;
            bit_idx_reg     <= 3'd0;
            shift_reg       <= 8'h00;
            byte_reg        <= 8'h00;
            byte_strobe_reg <= 1'b0;
            frame_err       <= 1'b0;
        end else begin
            rx_prev_reg     <= rx_s;
            byte_strobe_reg <= 1'b0;
            frame_err       <= 1'b0;
            case (rx_state_reg)
                RX_IDLE: begin
                    if (rx_prev_reg && !rx_s) begin
                        rx_state_reg <= RX_START;
                        bit_cnt_reg  <= '0;
                    end
                end
                RX_START: begin
                    if (bit_cnt_reg == HALF_LAST) begin
                        bit_cnt_reg <= '0;
                        if (!rx_s) begin
                            rx_state_reg <= RX_DATA;
                            bit_idx_reg  <= 3'd0;
                        end else begin
                            rx_state_reg <= RX_IDLE;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (bit_cnt_reg == FULL_LAST) begin
                        bit_cnt_reg <= '0;
                        shift_reg   <= {rx_s, shift_reg[7:1]};
                        bit_idx_reg <= bit_idx_reg + 3'd1;
                        if (bit_idx_reg == 3'd7) begin
                            rx_state_reg <= RX_STOP;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (bit_cnt_reg == FULL_LAST) begin
                        bit_cnt_reg <= '0;
                        if (rx_s) begin
                            byte_reg        <= shift_reg;
                            byte_strobe_reg <= 1'b1;
                            rx_state_reg    <= RX_IDLE;
                        end else begin
                            frame_err    <= 1'b1;
                            rx_state_reg <= RX_WAIT_HIGH;
                        end
                    end else begin
                        bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                RX_WAIT_HIGH: begin
                    if (rx_s) begin
                        rx_state_reg <= RX_IDLE;
                    end
                end
                default: rx_state_reg <= RX_IDLE;
            endcase
        end
    end

    // The parser only drains the holding register while it is collecting command/argument bytes.
    assign hold_take = hold_valid_reg && ((p_state_reg == P_CMD) || (p_state_reg == P_ARG));

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            hold_valid_reg <= 1'b0;
            hold_data_reg  <= 8'h00;
            overrun        <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (byte_strobe_reg) begin
                if (hold_valid_reg && !hold_take) begin
                    overrun <= 1'b1;
                end else begin
                    hold_data_reg  <= byte_reg;
                    hold_valid_reg <= 1'b1;
                end
            end else if (hold_take) begin
                hold_valid_reg <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge asyncrst_n) begin
        if (!asyncrst_n) begin
            p_state_reg    <= P_CMD;
            op_reg         <= 7'd0;
            arg_left_reg   <= 3'd0;
            arg_shift_reg  <= 24'h0;
            count_reg      <= 8'd1;
            reads_left_reg <= 8'd0;
            resp_buf_reg   <= 24'h0;
            resp_left_reg  <= 2'd0;
            bus_req        <= 1'b0;
            bus_we         <= 1'b0;
            bus_addr       <= 32'h0;
            bus_wdata      <= 32'h0;
            tx_valid       <= 1'b0;
            tx_data        <= 8'h00;
            core_rst       <= 1'b0;
        end else begin
            case (p_state_reg)
                P_CMD: begin
                    if (hold_take && hold_data_reg[7]) begin
                        op_reg <= hold_data_reg[6:0];
                        case (hold_data_reg[6:0])
                            OP_SET_COUNT: begin
                                arg_left_reg <= 3'd1;
                                p_state_reg  <= P_ARG;
                            end
                            OP_SET_ADDR, OP_WRITE: begin
                                arg_left_reg <= 3'd4;
                                p_state_reg  <= P_ARG;
                            end
                            OP_READ: begin
                                if (count_reg != 8'd0) begin
                                    reads_left_reg <= count_reg;
                                    bus_req        <= 1'b1;
                                    bus_we         <= 1'b0;
                                    p_state_reg    <= P_EXEC;
                                end
                            end
                            OP_ALIVE: begin
                                tx_valid      <= 1'b1;
                                tx_data       <= 8'h00;
                                resp_buf_reg  <= {8'hAE, 16'h0000};
                                resp_left_reg <= 2'd1;
                                p_state_reg   <= P_RESP;
                            end
                            OP_CORE_RST:  core_rst <= 1'b1;
                            OP_CORE_NORM: core_rst <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                P_ARG: begin
                    if (hold_take) begin
                        arg_shift_reg <= {arg_shift_reg[15:0], hold_data_reg};
                        if (arg_left_reg == 3'd1) begin
                            p_state_reg <= P_CMD;
                            case (op_reg)
                                OP_SET_COUNT: count_reg <= hold_data_reg;
                                OP_SET_ADDR:  bus_addr  <= {arg_shift_reg, hold_data_reg};
                                OP_WRITE: begin
                                    bus_wdata   <= {arg_shift_reg, hold_data_reg};
                                    bus_req     <= 1'b1;
                                    bus_we      <= 1'b1;
                                    p_state_reg <= P_EXEC;
                                end
                                default: ;
                            endcase
                        end else begin
                            arg_left_reg <= arg_left_reg - 3'd1;
                        end
                    end
                end
                P_EXEC: begin
                    if (bus_ack) begin
                        bus_req  <= 1'b0;
                        bus_we   <= 1'b0;
                        bus_addr <= bus_addr + 32'd4;
                        if (bus_we) begin
                            p_state_reg <= P_CMD;
                        end else begin
                            tx_valid       <= 1'b1;
                            tx_data        <= bus_rdata[31:24];
                            resp_buf_reg   <= bus_rdata[23:0];
                            resp_left_reg  <= 2'd3;
                            reads_left_reg <= reads_left_reg - 8'd1;
                            p_state_reg    <= P_RESP;
                        end
                    end
                end
                P_RESP: begin
                    if (tx_ready) begin
                        if (resp_left_reg == 2'd0) begin
                            tx_valid <= 1'b0;
                            // Remaining reads of a READ_DATA burst chain straight back into EXEC.
                            if (reads_left_reg != 8'd0) begin
                                bus_req     <= 1'b1;
                                bus_we      <= 1'b0;
                                p_state_reg <= P_EXEC;
                            end else begin
                                p_state_reg <= P_CMD;
                            end
                        end else begin
                            tx_data       <= resp_buf_reg[23:16];
                            resp_buf_reg  <= {resp_buf_reg[15:0], 8'h00};
                            resp_left_reg <= resp_left_reg - 2'd1;
                        end
                    end
                end
                default: p_state_reg <= P_CMD;
            endcase
        end
    end

endmodule
